// File: rtl/ksa_gen.sv
// RC4-style key-scheduling engine driving an external single-port synchronous S-box RAM.
// Optional identity-fill pass, then six cycles per index: read S[i], read S[j], write both.
module ksa_gen #(
  parameter int KEY_BYTES = 3,
  parameter int AW        = 8,
  parameter int INIT_EN   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  output logic                   done,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [AW-1:0]          addr,
  input  logic [AW-1:0]          rddata,
  output logic [AW-1:0]          wrdata,
  output logic                   wren
);

  localparam int            KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [AW-1:0] LAST_I = '1;
  localparam logic [KW-1:0] LAST_K = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_J, WR_I
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            i_q, i_d, j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  logic [AW-1:0]            si_q, si_d, sj_q, sj_d;
  logic [AW-1:0]            addr_q, addr_d, wrdata_q, wrdata_d;
  logic                     wren_q, wren_d, rdy_q, rdy_d, done_q, done_d;

  // Key byte k (byte 0 is the most significant), truncated or zero-extended to AW bits.
  function automatic logic [AW-1:0] key_byte(input logic [8*KEY_BYTES-1:0] kv,
                                             input logic [KW-1:0]          idx);
    logic [7:0] b;
    b = 8'(kv >> (8 * (KEY_BYTES - 1 - int'(idx))));
    return AW'(b);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  // Key copy and swap operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    key_q <= key_d;
    si_q  <= si_d;
    sj_q  <= sj_d;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    key_d   = key_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = (INIT_EN != 0) ? FILL : RD_I;
        end
      end
      FILL: begin
        i_d = i_q + 1'b1;
        if (i_q == LAST_I) state_d = RD_I;
      end
      RD_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte(key_q, k_q);
        state_d = RD_J;
      end
      RD_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = rddata;
        state_d = WR_J;
      end
      WR_J:  state_d = WR_I;
      WR_I: begin
        i_d     = i_q + 1'b1;
        k_d     = (k_q == LAST_K) ? '0 : k_q + 1'b1;
        state_d = (i_q == LAST_I) ? IDLE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: they are derived from the state being entered.
  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rdy_d    = (state_d == IDLE);
    done_d   = (state_q == WR_I) && (state_d == IDLE);
    case (state_d)
      FILL: begin
        addr_d   = i_d;
        wrdata_d = i_d;
        wren_d   = 1'b1;
      end
      RD_I: addr_d = i_d;
      RD_J: addr_d = j_d;
      WR_J: begin
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
      end
      WR_I: begin
        addr_d   = i_q;
        wrdata_d = sj_q;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;
  assign rdy    = rdy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ksa_gen.sv
// Bench for ksa_gen: four configurations, each with its own behavioural S-box RAM,
// checked against a plain RC4 key-schedule reference model.
module tb_ksa_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       enA, rdyA, doneA, wrenA;
  logic [7:0] keyA;
  logic [1:0] addrA, wrdataA, rddataA;
  logic [1:0] memA [4];

  logic        enB, rdyB, doneB, wrenB;
  logic [23:0] keyB;
  logic [7:0]  addrB, wrdataB, rddataB;
  logic [7:0]  memB [256];

  logic        enC, rdyC, doneC, wrenC, ldC;
  logic [23:0] keyC;
  logic [7:0]  addrC, wrdataC, rddataC;
  logic [7:0]  memC [256];

  logic        enD, rdyD, doneD, wrenD;
  logic [39:0] keyD;
  logic [3:0]  addrD, wrdataD, rddataD;
  logic [3:0]  memD [16];

  ksa_gen #(.KEY_BYTES(1), .AW(2), .INIT_EN(1)) dutA (
    .clk(clk), .rst_n(rst_n), .en(enA), .rdy(rdyA), .done(doneA), .key(keyA),
    .addr(addrA), .rddata(rddataA), .wrdata(wrdataA), .wren(wrenA));
  ksa_gen #(.KEY_BYTES(3), .AW(8), .INIT_EN(1)) dutB (
    .clk(clk), .rst_n(rst_n), .en(enB), .rdy(rdyB), .done(doneB), .key(keyB),
    .addr(addrB), .rddata(rddataB), .wrdata(wrdataB), .wren(wrenB));
  ksa_gen #(.KEY_BYTES(3), .AW(8), .INIT_EN(0)) dutC (
    .clk(clk), .rst_n(rst_n), .en(enC), .rdy(rdyC), .done(doneC), .key(keyC),
    .addr(addrC), .rddata(rddataC), .wrdata(wrdataC), .wren(wrenC));
  ksa_gen #(.KEY_BYTES(5), .AW(4), .INIT_EN(1)) dutD (
    .clk(clk), .rst_n(rst_n), .en(enD), .rdy(rdyD), .done(doneD), .key(keyD),
    .addr(addrD), .rddata(rddataD), .wrdata(wrdataD), .wren(wrenD));

  always @(posedge clk) begin
    if (wrenA) memA[addrA] <= wrdataA;
    rddataA <= memA[addrA];
  end
  always @(posedge clk) begin
    if (wrenB) memB[addrB] <= wrdataB;
    rddataB <= memB[addrB];
  end
  always @(posedge clk) begin
    if (ldC) for (int x = 0; x < 256; x++) memC[x] <= 8'(x);
    else if (wrenC) memC[addrC] <= wrdataC;
    rddataC <= memC[addrC];
  end
  always @(posedge clk) begin
    if (wrenD) memD[addrD] <= wrdataD;
    rddataD <= memD[addrD];
  end

  // Free-running busy-cycle and done-pulse counters; tests take differences.
  int busyA = 0, busyB = 0, busyC = 0, busyD = 0;
  int dnA = 0, dnB = 0, dnC = 0, dnD = 0;
  int trD [$];
  always @(negedge clk) begin
    if (!rdyA) busyA <= busyA + 1;
    if (!rdyB) busyB <= busyB + 1;
    if (!rdyC) busyC <= busyC + 1;
    if (!rdyD) busyD <= busyD + 1;
    if (doneA) dnA <= dnA + 1;
    if (doneB) dnB <= dnB + 1;
    if (doneC) dnC <= dnC + 1;
    if (doneD) dnD <= dnD + 1;
  end
  always @(negedge clk) if (wrenD) trD.push_back(int'(addrD) * 1024 + int'(wrdataD));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: textbook RC4 key schedule, also logging the expected write sequence.
  int ms [256];
  int exp_tr [$];
  task automatic model(input int n, input int kbn, input logic [63:0] k);
    int j, t, kb;
    for (int x = 0; x < n; x++) begin
      ms[x] = x;
      exp_tr.push_back(x * 1024 + x);
    end
    j = 0;
    for (int x = 0; x < n; x++) begin
      kb = int'((k >> (8 * (kbn - 1 - (x % kbn)))) & 64'hFF) % n;
      j  = (j + ms[x] + kb) % n;
      t  = ms[x];
      exp_tr.push_back(j * 1024 + t);
      exp_tr.push_back(x * 1024 + ms[j]);
      ms[x] = ms[j];
      ms[j] = t;
    end
  endtask

  function automatic logic rdy_v(input int idx);
    case (idx)
      0: return rdyA;
      1: return rdyB;
      2: return rdyC;
      default: return rdyD;
    endcase
  endfunction
  function automatic logic done_v(input int idx);
    case (idx)
      0: return doneA;
      1: return doneB;
      2: return doneC;
      default: return doneD;
    endcase
  endfunction
  function automatic int busy_v(input int idx);
    case (idx)
      0: return busyA;
      1: return busyB;
      2: return busyC;
      default: return busyD;
    endcase
  endfunction
  function automatic int dn_v(input int idx);
    case (idx)
      0: return dnA;
      1: return dnB;
      2: return dnC;
      default: return dnD;
    endcase
  endfunction
  task automatic set_en(input int idx, input logic v);
    case (idx)
      0: enA = v;
      1: enB = v;
      2: enC = v;
      default: enD = v;
    endcase
  endtask
  task automatic set_key(input int idx, input logic [63:0] k);
    case (idx)
      0: keyA = k[7:0];
      1: keyB = k[23:0];
      2: keyC = k[23:0];
      default: keyD = k[39:0];
    endcase
  endtask
  function automatic int mem_diff(input int idx, input int n);
    int d = 0;
    for (int x = 0; x < n; x++) begin
      case (idx)
        1: if (int'(memB[8'(x)]) != ms[x]) d++;
        2: if (int'(memC[8'(x)]) != ms[x]) d++;
        default: if (int'(memD[4'(x)]) != ms[x]) d++;
      endcase
    end
    return d;
  endfunction

  // One start/complete run; optionally re-pulses en 'poke' cycles into the run.
  task automatic run(input int idx, input int limit, input int poke,
                     output int busy, output int dn);
    int b0, d0, n;
    @(negedge clk);
    b0 = busy_v(idx);
    d0 = dn_v(idx);
    set_en(idx, 1'b1);
    @(negedge clk);
    set_en(idx, 1'b0);
    n = 0;
    while (!rdy_v(idx) && n < limit) begin
      set_en(idx, n == poke);
      @(negedge clk);
      n++;
    end
    set_en(idx, 1'b0);
    chk("run_within_budget", (n < limit) ? 1 : 0, 1);
    chk("done_with_rdy", done_v(idx), 1);
    busy = busy_v(idx) - b0;
    @(negedge clk);
    dn = dn_v(idx) - d0;
  endtask

  typedef struct {
    logic [7:0] key;
    logic [7:0] s;     // {S[0],S[1],S[2],S[3]}, two bits each
  } vec_t;
  vec_t tbl [5];

  initial begin
    int busy, dn, d0, cyc, hi, dones, t0, bad;
    logic [63:0] k;

    rst_n = 1'b0;
    enA = 0; enB = 0; enC = 0; enD = 0; ldC = 0;
    keyA = '0; keyB = '0; keyC = '0; keyD = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdyB, 1);
    chk("rst_done", doneB, 0);
    chk("rst_wren", wrenB, 0);
    chk("rst_addr", addrB, 0);
    chk("rst_wrdata", wrdataB, 0);
    chk("rst_rdyA", rdyA, 1);
    rst_n = 1'b1;

    tbl[0] = '{8'h00, 8'h2D};
    tbl[1] = '{8'h01, 8'h2D};
    tbl[2] = '{8'h02, 8'h8D};
    tbl[3] = '{8'h03, 8'h4E};
    tbl[4] = '{8'hFE, 8'h8D};
    for (int t = 0; t < 5; t++) begin
      set_key(0, 64'(tbl[t].key));
      run(0, 100, -1, busy, dn);
      chk("A_sbox", {memA[0], memA[1], memA[2], memA[3]}, tbl[t].s);
      chk("A_busy", busy, 28);
      chk("A_done_pulses", dn, 1);
    end

    for (int r = 0; r < 4; r++) begin
      k = (r == 0) ? 64'h00033C : (64'($urandom) & 64'hFFFFFF);
      set_key(1, k);
      run(1, 2500, (r == 2) ? 500 : -1, busy, dn);
      model(256, 3, k);
      chk("B_sbox_diff", mem_diff(1, 256), 0);
      chk("B_busy", busy, 1792);
      chk("B_done_pulses", dn, 1);
    end

    for (int r = 0; r < 2; r++) begin
      k = (r == 0) ? 64'h00033C : (64'($urandom) & 64'hFFFFFF);
      @(negedge clk); ldC = 1'b1;
      @(negedge clk); ldC = 1'b0;
      set_key(2, k);
      run(2, 2000, -1, busy, dn);
      model(256, 3, k);
      chk("C_sbox_diff", mem_diff(2, 256), 0);
      chk("C_busy", busy, 1536);
      chk("C_done_pulses", dn, 1);
    end

    // Asynchronous reset around i=100, then a clean run.
    @(negedge clk);
    keyB = 24'($urandom);
    enB = 1'b1;
    @(negedge clk);
    enB = 1'b0;
    repeat (856) @(negedge clk);
    chk("B_busy_before_reset", rdyB, 0);
    d0 = dnB;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", rdyB, 1);
    chk("arst_done", doneB, 0);
    chk("arst_wren", wrenB, 0);
    chk("arst_addr", addrB, 0);
    chk("arst_wrdata", wrdataB, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", dnB - d0, 0);
    chk("arst_stays_idle", rdyB, 1);
    k = 64'($urandom) & 64'hFFFFFF;
    set_key(1, k);
    run(1, 2500, -1, busy, dn);
    model(256, 3, k);
    chk("B_after_reset_diff", mem_diff(1, 256), 0);
    chk("B_after_reset_busy", busy, 1792);

    // en held high: two back-to-back runs with one idle rdy cycle between.
    k = {32'($urandom), 8'($urandom)};
    exp_tr.delete();
    model(16, 5, k);
    model(16, 5, k);
    @(negedge clk);
    t0 = trD.size();
    keyD = k[39:0];
    enD = 1'b1;
    cyc = 0; hi = 0; dones = 0;
    while (dones < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rdyD) hi++;
      if (doneD) dones++;
    end
    enD = 1'b0;
    chk("D_done_pulses", dones, 2);
    chk("D_total_cycles", cyc, 226);
    chk("D_idle_cycles", hi, 2);
    @(negedge clk);
    chk("D_no_third_run", rdyD, 1);
    chk("D_trace_len", trD.size() - t0, exp_tr.size());
    bad = 0;
    for (int x = 0; x < exp_tr.size(); x++)
      if (t0 + x >= trD.size() || trD[t0 + x] != exp_tr[x]) bad++;
    chk("D_trace_diff", bad, 0);
    chk("D_sbox_diff", mem_diff(3, 16), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
